// File: rtl/fetch_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | fetch_unit_pkg : shared PCSrc encodings, fetch FSM states, core opcodes     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_unit_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READY = 3'd2,
`ifdef PC_ALIGN_CHECK_EN
    ST_FAULT = 3'd4,
`endif
    ST_HALT  = 3'd3
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_ORI   = 6'b010000;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  function automatic logic [5:0] get_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_next_pc.sv
// +----------------------------------------------------------------------------+
// | fetch_next_pc : combinational next-PC selection (seq / branch / jr / jump)  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_next_pc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_instr_index,
  input  logic [1:0]  i_pc_src,
  input  logic [31:0] i_imm_ext,
  input  logic [31:0] i_rs_data,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_branch_target;

  assign o_pc_plus4      = i_pc + 32'd4;
  // Branch offset is in words; arithmetic wraps modulo 2^32.
  assign w_branch_target = o_pc_plus4 + (i_imm_ext << 2);

  always_comb begin
    o_next_pc = o_pc_plus4;
    case (i_pc_src)
      PC_SEQ:  o_next_pc = o_pc_plus4;
      PC_BR:   o_next_pc = w_branch_target;
      PC_REG:  o_next_pc = i_rs_data;
      PC_JMP:  o_next_pc = {o_pc_plus4[31:28], i_instr_index, 2'b00};
      default: o_next_pc = o_pc_plus4;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------------+
// | fetch_unit : IF stage - PC, req/ack instruction fetch, fetch buffer and IR  |
// | Optional feature macro: PC_ALIGN_CHECK_EN (misaligned-PC fault)             |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = OP_HALT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWre,
  input  logic        IRWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs_data,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic        fetch_busy,
`ifdef PC_ALIGN_CHECK_EN
  output logic        misalign_fault,
`endif
  output logic        halted
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_ir;
  logic [31:0]  r_fbuf;
  logic         r_fvalid;
  logic         r_im_req;
  logic         r_halted;
  logic [31:0]  w_next_pc;
`ifdef PC_ALIGN_CHECK_EN
  logic         r_misalign;
`endif

  fetch_next_pc u_next_pc (
    .i_pc          (r_pc),
    .i_instr_index (r_ir[25:0]),
    .i_pc_src      (PCSrc),
    .i_imm_ext     (imm_ext),
    .i_rs_data     (rs_data),
    .o_pc_plus4    (pc_plus4),
    .o_next_pc     (w_next_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_ir     <= 32'h0;
      r_fbuf   <= 32'h0;
      r_fvalid <= 1'b0;
      r_im_req <= 1'b0;
      r_halted <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_im_req <= 1'b1;
          r_state  <= ST_REQ;
        end
        // PCWre is deliberately not looked at here: an ack wins over it.
        ST_REQ: begin
          if (im_ack) begin
            r_fbuf   <= im_rdata;
            r_fvalid <= 1'b1;
            r_im_req <= 1'b0;
            r_state  <= ST_READY;
          end
        end
        ST_READY: begin
          if (PCWre) begin
            r_pc     <= w_next_pc;
            r_fvalid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (w_next_pc[1:0] != 2'b00) begin
              r_misalign <= 1'b1;
              r_state    <= ST_FAULT;
            end else begin
              r_im_req <= 1'b1;
              r_state  <= ST_REQ;
            end
`else
            r_im_req <= 1'b1;
            r_state  <= ST_REQ;
`endif
          end
        end
        default: ;
      endcase

      // Loading the halt word overrides any state change made above.
      if (IRWre && r_fvalid) begin
        r_ir <= r_fbuf;
        if (get_opcode(r_fbuf) == HALT_OPCODE) begin
          r_halted <= 1'b1;
          r_im_req <= 1'b0;
          r_state  <= ST_HALT;
        end
      end
    end
  end

  assign im_req     = r_im_req;
  assign im_addr    = r_pc;
  assign pc         = r_pc;
  assign ir         = r_ir;
  assign opcode     = get_opcode(r_ir);
  assign fetch_busy = ~r_fvalid;
  assign halted     = r_halted;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign_fault = r_misalign;
`endif

endmodule

`default_nettype wire
